// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared constants for the NPC instruction fetch unit
package ysyx_25020047_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQ      = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] OUT      = 3'd3;
  localparam logic [2:0] WAIT_NPC = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// rtl/ysyx_25020047_ifu.sv - single-outstanding instruction fetch unit
// Fetches one word per instruction, hands it to the decoder, then waits for writeback's next PC.
module ysyx_25020047_ifu
  import ysyx_25020047_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = REQ;
      REQ:      if (imem_req_ready) state_d = WAIT;
      WAIT:     if (imem_rsp_valid) state_d = OUT;
      OUT:      if (inst_ready) state_d = WAIT_NPC;
      WAIT_NPC: if (npc_valid) state_d = (npc[1:0] == 2'b00) ? REQ : OUT;
      default:  state_d = IDLE;
    endcase
  end

  // A misaligned next PC skips memory entirely and is presented as a faulted bubble.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    if (state_q == WAIT && imem_rsp_valid) begin
      inst_d  = imem_rsp_data;
      fault_d = imem_rsp_err;
    end
    if (state_q == WAIT_NPC && npc_valid) begin
      pc_d = npc;
      if (npc[1:0] != 2'b00) begin
        inst_d  = '0;
        fault_d = 1'b1;
      end
    end
  end

  always_comb begin
    imem_req_valid = (state_q == REQ);
    inst_valid     = (state_q == OUT);
    imem_req_addr  = pc_q;
    pc             = pc_q;
    inst           = inst_q;
    fetch_fault    = fault_q;
  end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// tb/tb_ysyx_25020047_ifu.sv - directed self-checking bench for the fetch unit
module tb_ysyx_25020047_ifu;
  import ysyx_25020047_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready, fetch_fault, npc_valid;
  logic [31:0] inst, pc, npc;

  ysyx_25020047_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .fetch_fault(fetch_fault), .npc_valid(npc_valid), .npc(npc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc = 32'h8000_0000;
  int total = 0, bad = 0;
  int req_cnt = 0, hand_cnt = 0, cyc = 0, hand_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'hA5A5_0000 ^ NOP;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a == 32'h8000_0040;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Every fetch address the bench hands out predicts exactly one decoder handoff.
  task automatic model_fetch(input logic [31:0] a);
    model_pc = a;
    if (a[1:0] == 2'b00) exp_q.push_back(exp_t'{pc: a, inst: mem_word(a), f: mem_err(a)});
    else                 exp_q.push_back(exp_t'{pc: a, inst: 32'h0, f: 1'b1});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    npc_valid = 1'b0;
    step;
    exp_q.delete();
    model_fetch(32'h8000_0000);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc", pc, 32'h8000_0000);
    repeat (n - 1) step;
  endtask

  task automatic release_rst(input bit stray);
    rst = 1'b0;
    if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFFFF_FFFF;
      imem_rsp_err   = 1'b1;
    end
    step;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
  endtask

  task automatic wait_req;
    for (int i = 0; i < 20 && !imem_req_valid; i++) step;
    chk("req_timeout", imem_req_valid, 1);
  endtask

  task automatic wait_out;
    for (int i = 0; i < 20 && !inst_valid; i++) step;
    chk("out_timeout", inst_valid, 1);
  endtask

  // Memory side: optional stall, optional response delay; stray responses during stall must be ignored.
  task automatic serve_mem(input int req_stall, input int rsp_delay, input bit stray_npc, input bit abort);
    logic [31:0] a;
    wait_req;
    imem_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      step;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    a = imem_req_addr;
    step;
    imem_req_ready = 1'b0;
    if (abort) return;
    if (stray_npc) begin
      npc_valid = 1'b1;
      npc = 32'hDEAD_BEE0;
    end
    repeat (rsp_delay) step;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(a);
    imem_rsp_err   = mem_err(a);
    step;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    npc_valid = 1'b0;
  endtask

  task automatic take_out(input int stall);
    wait_out;
    inst_ready = 1'b0;
    repeat (stall) step;
    inst_ready = 1'b1;
    step;
    inst_ready = 1'b0;
  endtask

  task automatic give_npc(input logic [31:0] a);
    npc_valid = 1'b1;
    npc = a;
    step;
    npc_valid = 1'b0;
    model_fetch(a);
  endtask

  // Monitor: pc tracking, request legality, handshake stability and scoreboard on every cycle.
  initial begin
    logic pv_req, pr_req, pv_out, pr_out, p_f;
    logic [31:0] p_inst, p_pc;
    exp_t e;
    pv_req = 0; pr_req = 0; pv_out = 0; pr_out = 0; p_f = 0; p_inst = 0; p_pc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pv_req = 0;
        pv_out = 0;
      end else begin
        chk("pc_track", pc, model_pc);
        if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
        if (model_pc[1:0] != 2'b00) chk("no_req_misaligned", imem_req_valid, 0);
        if (pv_req && !pr_req) chk("req_hold", imem_req_valid, 1);
        if (pv_out && !pr_out) begin
          chk("out_hold", inst_valid, 1);
          chk("inst_hold", inst, p_inst);
          chk("pc_hold", pc, p_pc);
          chk("fault_hold", fetch_fault, p_f);
        end
        if (imem_req_valid && imem_req_ready) req_cnt++;
        if (inst_valid && inst_ready) begin
          hand_cnt++;
          hand_cyc = cyc;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: got handoff pc=%h want none", pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_inst", inst, e.inst);
            chk("sb_fault", fetch_fault, e.f);
          end
        end
        pv_req = imem_req_valid; pr_req = imem_req_ready;
        pv_out = inst_valid;     pr_out = inst_ready;
        p_inst = inst; p_pc = pc; p_f = fetch_fault;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, h0, prev;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    inst_ready = 0; npc_valid = 0; npc = 0;

    do_reset(2);
    release_rst(0);
    serve_mem(0, 0, 0, 0);
    wait_out;
    chk("lit_first_inst", inst, 32'h0010_0093);
    chk("lit_first_pc", pc, 32'h8000_0000);
    chk("lit_first_fault", fetch_fault, 0);
    take_out(0);

    r0 = req_cnt; h0 = hand_cnt;
    give_npc(32'h8000_0010);
    chk("lit_npc_req_addr", imem_req_addr, 32'h8000_0010);
    serve_mem(5, 0, 0, 0);
    take_out(4);
    chk("bp_one_req", req_cnt - r0, 1);
    chk("bp_one_handoff", hand_cnt - h0, 1);

    give_npc(32'h8000_0020);
    serve_mem(0, 2, 1, 0);
    take_out(0);
    chk("lit_pc_after_stray_npc", pc, 32'h8000_0020);

    r0 = req_cnt;
    give_npc(32'h8000_0006);
    wait_out;
    chk("lit_mis_inst", inst, 32'h0);
    chk("lit_mis_fault", fetch_fault, 1);
    chk("lit_mis_pc", pc, 32'h8000_0006);
    take_out(1);
    chk("mis_no_req", req_cnt - r0, 0);

    give_npc(32'h8000_0040);
    serve_mem(0, 0, 0, 0);
    wait_out;
    chk("lit_err_fault", fetch_fault, 1);
    chk("lit_err_inst", inst, 32'h25A5_0053);
    take_out(0);

    give_npc(32'hFFFF_FFFC);
    serve_mem(0, 1, 0, 0);
    take_out(0);

    give_npc(32'h8000_0080);
    serve_mem(0, 0, 0, 1);
    do_reset(1);
    release_rst(1);
    serve_mem(0, 0, 0, 0);
    take_out(0);

    give_npc(32'h8000_0090);
    serve_mem(0, 0, 0, 0);
    wait_out;
    do_reset(1);
    release_rst(0);
    serve_mem(0, 0, 0, 0);
    take_out(0);

    prev = 0;
    for (int i = 0; i < 10; i++) begin
      give_npc(32'h8000_0100 + 32'(4 * i));
      serve_mem(0, 0, 0, 0);
      take_out(0);
      if (i > 0) chk("b2b_period", hand_cyc - prev, 4);
      prev = hand_cyc;
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
